// File: rtl/gb_csr_bank_if.sv
// Ghostbus local port bundle: host address/data/strobes plus the read return path.
interface gb_csr_bank_if #(
  parameter int AW = 12,
  parameter int DW = 32
);
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_dout;
  logic          gb_we;
  logic          gb_re;
  logic [DW-1:0] gb_din;
  logic          gb_din_valid;

  modport master (output gb_addr, gb_dout, gb_we, gb_re, input gb_din, gb_din_valid);
  modport slave  (input gb_addr, gb_dout, gb_we, gb_re, output gb_din, gb_din_valid);
endinterface

// File: rtl/gb_csr_bank.sv
// Ghostbus CSR bank: NCSR host/fabric-writable registers, one RAM window and a
// fixed-latency read return that drives this module's local gb_din contribution.

// One CSR lane: host write beats fabric update; the write strobe follows host writes only.
module gb_csr_reg #(
  parameter int            GW   = 8,
  parameter logic [GW-1:0] INIT = '0
) (
  input  logic          gb_clk,
  input  logic          gb_rst,
  input  logic          host_we,
  input  logic [GW-1:0] host_d,
  input  logic          hw_we,
  input  logic [GW-1:0] hw_d,
  output logic [GW-1:0] q,
  output logic          ws
);
  // Register value and a strobe aligned with the first cycle the new host value is visible.
  always_ff @(posedge gb_clk or posedge gb_rst)
    if (gb_rst) begin
      q  <= INIT;
      ws <= 1'b0;
    end else begin
      ws <= host_we;
      if (host_we)    q <= host_d;
      else if (hw_we) q <= hw_d;
    end
endmodule

module gb_csr_bank #(
  parameter int                 AW       = 12,
  parameter int                 DW       = 32,
  parameter int                 GW       = 8,
  parameter int                 NCSR     = 4,
  parameter logic [NCSR*GW-1:0] CSR_INIT = (NCSR*GW)'(32'h00000042),
  parameter int                 LAW      = 7,
  parameter int                 RAM_AW   = 3,
  parameter int                 RAM_DW   = 4,
  parameter int                 RAM_BASE = 'h40,
  parameter int                 RD_LAT   = 1
) (
  input  logic               gb_clk,
  input  logic               gb_rst,
  gb_csr_bank_if.slave       gb,
  output logic [NCSR*GW-1:0] csr_q,
  output logic [NCSR-1:0]    csr_ws,
  output logic [NCSR-1:0]    csr_rs,
  input  logic [NCSR-1:0]    csr_hw_we,
  input  logic [NCSR*GW-1:0] csr_hw_d,
  input  logic [RAM_AW-1:0]  ram_raddr,
  output logic [RAM_DW-1:0]  ram_rdata
);
  localparam int TW    = LAW - RAM_AW;
  localparam int DEPTH = 2 ** RAM_AW;
  localparam logic [TW-1:0] RAM_TAG = TW'(RAM_BASE >> RAM_AW);

  // Parameter sanity: bad combinations stop elaboration instead of silently aliasing.
  if (GW < 1 || GW > DW)                 begin : g_bad_gw   $error("gb_csr_bank: GW must be 1..DW");        end
  if (RAM_DW < 1 || RAM_DW > DW)         begin : g_bad_rdw  $error("gb_csr_bank: RAM_DW must be 1..DW");    end
  if (NCSR < 1 || NCSR > 64)             begin : g_bad_n    $error("gb_csr_bank: NCSR must be 1..64");      end
  if (RD_LAT != 1 && RD_LAT != 2)        begin : g_bad_lat  $error("gb_csr_bank: RD_LAT must be 1 or 2");   end
  if (RAM_BASE % DEPTH != 0)             begin : g_bad_algn $error("gb_csr_bank: RAM_BASE misaligned");     end
  if (RAM_BASE < NCSR)                   begin : g_bad_ovl  $error("gb_csr_bank: RAM overlaps CSRs");       end
  if (RAM_BASE + DEPTH > 2 ** LAW)       begin : g_bad_win  $error("gb_csr_bank: RAM outside local window"); end

  // ---------------- decode ----------------
  logic            loc, ram_hit, wr, rd, rd_vld;
  logic [NCSR-1:0] csr_hit;
  logic [RAM_AW-1:0] ram_waddr;

  assign loc       = (gb.gb_addr[AW-1:LAW] == '0);
  assign ram_hit   = loc && (gb.gb_addr[LAW-1:RAM_AW] == RAM_TAG);
  assign ram_waddr = gb.gb_addr[RAM_AW-1:0];
  assign wr        = gb.gb_we;
  assign rd        = gb.gb_re && !gb.gb_we;   // write wins when both are raised
  assign rd_vld    = rd && loc;               // non-local reads never answer

  // Upper host data bits beyond GW/RAM_DW are intentionally ignored.
  logic unused_dout;
  assign unused_dout = ^gb.gb_dout;

  // ---------------- CSR lanes ----------------
  for (genvar i = 0; i < NCSR; i++) begin : g_csr
    assign csr_hit[i] = loc && (gb.gb_addr[LAW-1:0] == LAW'(i));
    gb_csr_reg #(.GW(GW), .INIT(CSR_INIT[i*GW +: GW])) u_csr (
      .gb_clk  (gb_clk),
      .gb_rst  (gb_rst),
      .host_we (wr && csr_hit[i]),
      .host_d  (gb.gb_dout[GW-1:0]),
      .hw_we   (csr_hw_we[i]),
      .hw_d    (csr_hw_d[i*GW +: GW]),
      .q       (csr_q[i*GW +: GW]),
      .ws      (csr_ws[i])
    );
  end

  // ---------------- RAM ----------------
  logic [RAM_DW-1:0] ram [DEPTH];

  // Host write port; contents deliberately survive reset.
  always_ff @(posedge gb_clk)
    if (wr && ram_hit) ram[ram_waddr] <= gb.gb_dout[RAM_DW-1:0];

  // Fabric read port, read-first against a same-edge host write.
  always_ff @(posedge gb_clk or posedge gb_rst)
    if (gb_rst) ram_rdata <= '0;
    else        ram_rdata <= ram[ram_raddr];

  // ---------------- read return ----------------
  logic [DW-1:0]   rd_dat;
  logic [NCSR-1:0] rd_rs;

  // Stage-0 read data: zero unless an accepted local read selects a CSR or RAM word.
  always_comb begin
    rd_dat = '0;
    rd_rs  = '0;
    if (rd_vld) begin
      rd_rs = csr_hit;
      for (int i = 0; i < NCSR; i++)
        if (csr_hit[i]) rd_dat[GW-1:0] = csr_q[i*GW +: GW];
      if (ram_hit) rd_dat[RAM_DW-1:0] = ram[ram_waddr];
    end
  end

  // Index 0 is the live request, RD_LAT is the output stage; valid, data and strobe shift together.
  logic [RD_LAT:0]                vld_pipe;
  logic [RD_LAT:0][DW-1:0]        dat_pipe;
  logic [RD_LAT:0][NCSR-1:0]      rs_pipe;
  logic [RD_LAT-1:0]              vld_q;
  logic [RD_LAT-1:0][DW-1:0]      dat_q;
  logic [RD_LAT-1:0][NCSR-1:0]    rs_q;

  assign vld_pipe = {vld_q, rd_vld};
  assign dat_pipe = {dat_q, rd_dat};
  assign rs_pipe  = {rs_q, rd_rs};

  // Read pipeline registers; reset flushes any in-flight read.
  always_ff @(posedge gb_clk or posedge gb_rst)
    if (gb_rst) begin
      vld_q <= '0;
      dat_q <= '0;
      rs_q  <= '0;
    end else begin
      vld_q <= vld_pipe[RD_LAT-1:0];
      dat_q <= dat_pipe[RD_LAT-1:0];
      rs_q  <= rs_pipe[RD_LAT-1:0];
    end

  assign gb.gb_din       = dat_pipe[RD_LAT];
  assign gb.gb_din_valid = vld_pipe[RD_LAT];
  assign csr_rs          = rs_pipe[RD_LAT];
endmodule
